neurosync_engine: RTL and testbench
===================================

# neurosync_engine

Parametrised successor of the 4-button memory-game engine. It runs a Simon-style game over `N_BUTTONS` buttons and LEDs. Each round appends one pseudo-random element to a stored sequence of up to `SEQ_DEPTH` entries, replays the sequence on the LEDs, then checks the player's repetition under a per-move timeout. It sits between the board's conditioned button inputs and the LED and 7-segment display logic, and replaces the fixed-size control unit and datapath pair.

## Interface
- `N_BUTTONS`, 4: number of buttons and LEDs; power of two, 2..16; `IW = clog2(N_BUTTONS)`.
- `SEQ_DEPTH`, 16: maximum sequence length; even, 2..64; `RW = clog2(SEQ_DEPTH+1)`.
- `LED_ON_CYCLES`, 1000: LED lit time per displayed element.
- `LED_OFF_CYCLES`, 500: dark gap after each displayed element.
- `TIMEOUT_CYCLES`, 5000: maximum wait per player move.
- `clock` input 1: single rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `jogar` input 1: start request; acted on only in IDLE, WIN or LOSE.
- `nivel` input 1: sampled on the accepted `jogar`; 0 sets target length `SEQ_DEPTH/2`, 1 sets `SEQ_DEPTH`.
- `botoes` input N_BUTTONS: already synchronised and debounced, active-high.
- `leds` output N_BUTTONS: one-hot during sequence display, otherwise 0.
- `acertos` output RW: number of completed rounds.
- `pronto` output 1: high in WIN and LOSE.
- `ganhou` output 1: high in WIN.
- `perdeu` output 1: high in LOSE.
- `timeout` output 1: high in LOSE when the loss was caused by timeout.

## Operation
- Random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1. It advances every cycle in every state, including during reset deassertion.
- New element = `lfsr[IW-1:0]`, captured in APPEND.
- Sequence storage: `SEQ_DEPTH` × IW register file, written only in APPEND at index `acertos`.
- Move detection: a move is the cycle in which `botoes` is nonzero and the previous-cycle `botoes` was zero.
  - One bit set: the move value is that bit's index.
  - More than one bit set: the move is a mismatch.
- States and transitions:
  - IDLE: on `jogar`, latch `nivel`, clear `acertos`, go to APPEND.
  - APPEND: write the new element, clear the display index, go to SHOW_ON.
  - SHOW_ON: `leds` = one-hot of seq[display index] for `LED_ON_CYCLES` cycles, then go to SHOW_OFF.
  - SHOW_OFF: `leds` = 0 for `LED_OFF_CYCLES` cycles.
    - If display index = `acertos`, clear the move index and timer, go to WAIT.
    - Otherwise increment the display index and go to SHOW_ON.
  - WAIT: leave on move or timeout.
    - Move matching seq[move index]: if move index = `acertos`, go to ROUND_OK; otherwise increment the move index, clear the timer, stay in WAIT.
    - Mismatched move: go to LOSE with `timeout` = 0.
    - Timer reaches `TIMEOUT_CYCLES-1` with no move: go to LOSE with `timeout` = 1.
  - ROUND_OK: increment `acertos`.
    - If the new value = target length, go to WIN.
    - Otherwise go to APPEND.
  - WIN / LOSE: hold all outputs; `jogar` restarts exactly as from IDLE.
- Simultaneous events in WAIT: a move in the timeout cycle takes priority over timeout.
- Buttons pressed outside WAIT are ignored. A button still held when WAIT is entered does not count as a move until it is released and pressed again.
- `jogar` outside IDLE, WIN and LOSE is ignored; `nivel` changes mid-game are ignored.

## Timing
- Reset values: state IDLE, `leds` 0, `acertos` 0, `pronto` 0, `ganhou` 0, `perdeu` 0, `timeout` 0, all counters 0. The register-file contents are don't-care.
- Reset asserted in any state returns the block to IDLE on the next edge.
- All outputs are registered, or decoded from registered state only; there is no combinational path from inputs to outputs.
- `jogar` seen at edge k: APPEND at k+1, first LED lit from k+2.
- Round of length L (= `acertos`+1): display lasts exactly L·(`LED_ON_CYCLES`+`LED_OFF_CYCLES`) cycles.
- Move at edge k: the matching decision takes effect at k+1. The `acertos` increment is visible 2 cycles after the last correct move.
- Wrap-around cannot occur: `acertos` never exceeds the target length.

## Configuration
- `NEUROSYNC_DEBUG_EN`:
  - Defined: adds output ports `db_estado` [3:0] (state encoding IDLE=0, APPEND=1, SHOW_ON=2, SHOW_OFF=3, WAIT=4, ROUND_OK=5, WIN=6, LOSE=7), `db_jogada` [IW-1:0] (last move index, reset 0) and `db_sequencia` [IW-1:0] (seq[move index]).
  - Undefined: these ports and their logic are absent; functional behaviour is identical.

## Test plan
- Reset mid-SHOW_ON in round 3 → next cycle IDLE, `leds`=0, `acertos`=0, all flags 0.
- `N_BUTTONS`=4, `SEQ_DEPTH`=4, `nivel`=0: bench mirrors each displayed LED back → `acertos` 1 then 2, `ganhou`=1, `pronto`=1, `perdeu`=0.
- `nivel`=1, same parameters, perfect play → WIN only after `acertos`=4; round 4 display lasts 4·(ON+OFF) cycles exactly.
- Wrong button on the second move of round 2 → `perdeu`=1, `timeout`=0, `acertos`=1.
- No press after display with `TIMEOUT_CYCLES`=20 → LOSE 20 cycles after entering WAIT, `timeout`=1. Variant: press on cycle 19 → move accepted, no timeout.
- Two buttons pressed together in WAIT → LOSE, `timeout`=0. A held button carried into WAIT produces no move. `jogar` in LOSE → new game with `acertos`=0.

Source files
------------

// File: rtl/neurosync_engine.sv
// neurosync_engine
// ----------------
// Simon-style memory game engine over N_BUTTONS buttons/LEDs. Each round appends
// one pseudo-random element to a stored sequence, replays the whole sequence on
// the LEDs, then checks the player's repetition under a per-move timeout.
//
// Ports
//   clock    : rising-edge clock
//   reset    : synchronous, active-high
//   jogar    : start request, honoured only in IDLE, WIN and LOSE
//   nivel    : sampled with an accepted jogar; 0 -> SEQ_DEPTH/2 rounds, 1 -> SEQ_DEPTH
//   botoes   : synchronised, debounced buttons (active-high)
//   leds     : one-hot while an element is shown, otherwise 0
//   acertos  : number of completed rounds
//   pronto   : game over (WIN or LOSE)
//   ganhou   : WIN
//   perdeu   : LOSE
//   timeout  : LOSE caused by the per-move timer
//
// Optional debug ports, present only when NEUROSYNC_DEBUG_EN is defined:
//   db_estado    : state encoding (IDLE=0 .. LOSE=7)
//   db_jogada    : last single-button move seen in WAIT
//   db_sequencia : stored element at the current move index

module neurosync_engine #(
    parameter int N_BUTTONS      = 4,
    parameter int SEQ_DEPTH      = 16,
    parameter int LED_ON_CYCLES  = 1000,
    parameter int LED_OFF_CYCLES = 500,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 jogar,
    input  logic                                 nivel,
    input  logic [N_BUTTONS-1:0]                 botoes,
    output logic [N_BUTTONS-1:0]                 leds,
    output logic [$clog2(SEQ_DEPTH+1)-1:0]       acertos,
    output logic                                 pronto,
    output logic                                 ganhou,
    output logic                                 perdeu,
    output logic                                 timeout
`ifdef NEUROSYNC_DEBUG_EN
    ,
    output logic [3:0]                           db_estado,
    output logic [$clog2(N_BUTTONS)-1:0]         db_jogada,
    output logic [$clog2(N_BUTTONS)-1:0]         db_sequencia
`endif
);

    localparam int IW   = $clog2(N_BUTTONS);
    localparam int RW   = $clog2(SEQ_DEPTH + 1);
    localparam int AW   = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;
    localparam int TMAX = (LED_ON_CYCLES > LED_OFF_CYCLES)
                        ? ((LED_ON_CYCLES > TIMEOUT_CYCLES) ? LED_ON_CYCLES : TIMEOUT_CYCLES)
                        : ((LED_OFF_CYCLES > TIMEOUT_CYCLES) ? LED_OFF_CYCLES : TIMEOUT_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPEND   = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT     = 3'd4,
        S_ROUND_OK = 3'd5,
        S_WIN      = 3'd6,
        S_LOSE     = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q;
    logic [N_BUTTONS-1:0] botoes_prev_q;
    logic [RW-1:0]        acertos_q, acertos_d;
    logic                 nivel_q, nivel_d;
    logic [AW-1:0]        disp_idx_q, disp_idx_d;
    logic [AW-1:0]        move_idx_q, move_idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 timeout_q, timeout_d;
    logic [IW-1:0]        seq_q [SEQ_DEPTH];
    logic                 seq_we;

    logic                 move_evt;
    logic                 move_single;
    logic [IW-1:0]        move_val;
    logic [IW-1:0]        seq_at_move;
    logic [RW-1:0]        acertos_inc;
    logic [RW-1:0]        target_len;

    // ------------------------------------------------------------------
    // Free-running random source: right-shifting Fibonacci LFSR with
    // taps 16,14,13,11 (bit 0 is tap 16).
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // ------------------------------------------------------------------
    // Move detection. The previous-cycle sample is tracked in every state,
    // so a button still held on entry to WAIT never looks like a new press.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            botoes_prev_q <= '0;
        end else begin
            botoes_prev_q <= botoes;
        end
    end

    assign move_evt    = (botoes != '0) && (botoes_prev_q == '0);
    assign move_single = (botoes & (botoes - N_BUTTONS'(1))) == '0;

    always_comb begin
        move_val = '0;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            if (botoes[i]) begin
                move_val = IW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequence register file (no reset; contents are only read after
    // being written in the current game).
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (seq_we) begin
            seq_q[acertos_q[AW-1:0]] <= lfsr_q[IW-1:0];
        end
    end

    assign seq_at_move = seq_q[move_idx_q];
    assign acertos_inc = acertos_q + RW'(1);
    assign target_len  = nivel_q ? RW'(SEQ_DEPTH) : RW'(SEQ_DEPTH / 2);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acertos_q  <= '0;
            nivel_q    <= 1'b0;
            disp_idx_q <= '0;
            move_idx_q <= '0;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acertos_q  <= acertos_d;
            nivel_q    <= nivel_d;
            disp_idx_q <= disp_idx_d;
            move_idx_q <= move_idx_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        acertos_d  = acertos_q;
        nivel_d    = nivel_q;
        disp_idx_d = disp_idx_q;
        move_idx_d = move_idx_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        seq_we     = 1'b0;

        unique case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (jogar) begin
                    nivel_d   = nivel;
                    acertos_d = '0;
                    timeout_d = 1'b0;
                    state_d   = S_APPEND;
                end
            end

            S_APPEND: begin
                seq_we     = 1'b1;
                disp_idx_d = '0;
                timer_d    = '0;
                state_d    = S_SHOW_ON;
            end

            S_SHOW_ON: begin
                if (timer_q == TW'(LED_ON_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_SHOW_OFF;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_SHOW_OFF: begin
                if (timer_q == TW'(LED_OFF_CYCLES - 1)) begin
                    timer_d = '0;
                    if (RW'(disp_idx_q) == acertos_q) begin
                        move_idx_d = '0;
                        state_d    = S_WAIT;
                    end else begin
                        disp_idx_d = disp_idx_q + AW'(1);
                        state_d    = S_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_WAIT: begin
                // A move in the final timer cycle wins over the timeout.
                if (move_evt) begin
                    if (move_single && (move_val == seq_at_move)) begin
                        if (RW'(move_idx_q) == acertos_q) begin
                            state_d = S_ROUND_OK;
                        end else begin
                            move_idx_d = move_idx_q + AW'(1);
                            timer_d    = '0;
                        end
                    end else begin
                        timeout_d = 1'b0;
                        state_d   = S_LOSE;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_LOSE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_ROUND_OK: begin
                acertos_d = acertos_inc;
                if (acertos_inc == target_len) begin
                    state_d = S_WIN;
                end else begin
                    state_d = S_APPEND;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        leds = '0;
        if (state_q == S_SHOW_ON) begin
            leds = N_BUTTONS'(1) << seq_q[disp_idx_q];
        end
    end

    assign acertos = acertos_q;
    assign pronto  = (state_q == S_WIN) || (state_q == S_LOSE);
    assign ganhou  = (state_q == S_WIN);
    assign perdeu  = (state_q == S_LOSE);
    assign timeout = timeout_q && (state_q == S_LOSE);

`ifdef NEUROSYNC_DEBUG_EN
    logic [IW-1:0] db_jogada_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            db_jogada_q <= '0;
        end else if ((state_q == S_WAIT) && move_evt && move_single) begin
            db_jogada_q <= move_val;
        end
    end

    assign db_estado    = {1'b0, state_q};
    assign db_jogada    = db_jogada_q;
    assign db_sequencia = seq_at_move;
`endif

endmodule

// File: tb/tb_neurosync_engine.sv
// Directed bench for neurosync_engine with N_BUTTONS=4, SEQ_DEPTH=4,
// short LED/timeout constants. Displayed LEDs are mirrored back as moves.

module tb_neurosync_engine;

    localparam int NB  = 4;
    localparam int SD  = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int TO  = 20;

    logic          clock;
    logic          reset;
    logic          jogar;
    logic          nivel;
    logic [NB-1:0] botoes;
    logic [NB-1:0] leds;
    logic [2:0]    acertos;
    logic          pronto;
    logic          ganhou;
    logic          perdeu;
    logic          timeout;

    int vectors;
    int miscompares;

    logic [NB-1:0] disp_seq [SD];

    neurosync_engine #(
        .N_BUTTONS      (NB),
        .SEQ_DEPTH      (SD),
        .LED_ON_CYCLES  (ON),
        .LED_OFF_CYCLES (OFF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .jogar   (jogar),
        .nivel   (nivel),
        .botoes  (botoes),
        .leds    (leds),
        .acertos (acertos),
        .pronto  (pronto),
        .ganhou  (ganhou),
        .perdeu  (perdeu),
        .timeout (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          rst;
        logic          jog;
        logic          niv;
        logic [NB-1:0] btn;
        logic          exp_show;   // 1: leds must be one-hot, 0: leds must be 0
        logic [2:0]    exp_acertos;
        logic [3:0]    exp_flags;  // {pronto, ganhou, perdeu, timeout}
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input int acc, input logic [3:0] flags);
        chk({name, ".acertos"}, int'(acertos), acc);
        chk({name, ".pronto"},  int'(pronto),  int'(flags[3]));
        chk({name, ".ganhou"},  int'(ganhou),  int'(flags[2]));
        chk({name, ".perdeu"},  int'(perdeu),  int'(flags[1]));
        chk({name, ".timeout"}, int'(timeout), int'(flags[0]));
    endtask

    task automatic start_game(input logic lvl);
        botoes = '0;
        jogar  = 1'b1;
        nivel  = lvl;
        tick();
        jogar  = 1'b0;
        chk_out("start", 0, 4'b0000);
        chk("start.leds", int'(leds), 0);
    endtask

    // Entered with the DUT in APPEND; returns with it freshly in WAIT.
    task automatic watch_display(input int len);
        logic [NB-1:0] cur;
        tick();
        for (int e = 0; e < len; e++) begin
            if (e > 0) tick();
            cur = leds;
            chk("led_onehot", $countones(cur), 1);
            if (e < len - 1) chk("seq_keep", int'(cur), int'(disp_seq[e]));
            else             disp_seq[e] = cur;
            for (int c = 1; c < ON; c++) begin
                tick();
                chk("led_hold", int'(leds), int'(cur));
            end
            for (int c = 0; c < OFF; c++) begin
                tick();
                chk("led_off", int'(leds), 0);
            end
        end
        tick();
        chk("wait_dark", int'(leds), 0);
    endtask

    task automatic press(input logic [NB-1:0] v);
        botoes = v;
        tick();
        botoes = '0;
        tick();
    endtask

    task automatic play_round(input int r, input logic win);
        watch_display(r);
        for (int m = 0; m < r - 1; m++) begin
            press(disp_seq[m]);
            chk("mid_round.perdeu", int'(perdeu), 0);
        end
        botoes = disp_seq[r-1];
        tick();
        chk("acc_hold", int'(acertos), r - 1);
        botoes = '0;
        tick();
        chk_out("round_end", r, win ? 4'b1100 : 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        jogar  = 1'b0;
        nivel  = 1'b0;
        botoes = '0;
        for (int i = 0; i < SD; i++) disp_seq[i] = '0;

        //           rst   jog   niv   btn      show  acc   flags
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 3'd0, 4'b0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd0, 4'b0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b0000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0, 4'b0000};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 3'd0, 4'b0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd0, 4'b0000};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b0000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b0000};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 3'd0, 4'b0000};

        for (int i = 0; i < 12; i++) begin
            reset  = tbl[i].rst;
            jogar  = tbl[i].jog;
            nivel  = tbl[i].niv;
            botoes = tbl[i].btn;
            tick();
            if (tbl[i].exp_show) chk($sformatf("vec%0d.leds_onehot", i), $countones(leds), 1);
            else                 chk($sformatf("vec%0d.leds_zero", i), int'(leds), 0);
            chk_out($sformatf("vec%0d", i), int'(tbl[i].exp_acertos), tbl[i].exp_flags);
        end
        reset = 1'b0;
        jogar = 1'b0;
        nivel = 1'b0;

        // Timeout with no press: WAIT was entered at vec10; timer is now 1.
        botoes = '0;
        for (int i = 0; i < 18; i++) tick();
        chk_out("to_edge", 0, 4'b0000);
        tick();
        chk_out("to_lose", 0, 4'b1011);

        // Press on the last timer cycle is accepted; then wrong 2nd move in round 2.
        start_game(1'b0);
        watch_display(1);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("late.perdeu", int'(perdeu), 0);
        botoes = disp_seq[0];
        tick();
        chk_out("late_move", 0, 4'b0000);
        botoes = '0;
        tick();
        chk_out("late_round", 1, 4'b0000);
        watch_display(2);
        press(disp_seq[0]);
        chk("r2m1.perdeu", int'(perdeu), 0);
        botoes = {disp_seq[1][NB-2:0], disp_seq[1][NB-1]};
        tick();
        botoes = '0;
        chk_out("wrong_btn", 1, 4'b1010);

        // Restart from LOSE, short game played perfectly.
        start_game(1'b0);
        play_round(1, 1'b0);
        play_round(2, 1'b1);
        botoes = 4'b1111;
        nivel  = 1'b1;
        tick();
        botoes = '0;
        tick();
        tick();
        chk_out("win_hold", 2, 4'b1100);
        chk("win_hold.leds", int'(leds), 0);

        // Long game; jogar/nivel disturbances mid-game are ignored.
        start_game(1'b1);
        play_round(1, 1'b0);
        play_round(2, 1'b0);
        jogar = 1'b1;
        nivel = 1'b0;
        play_round(3, 1'b0);
        jogar = 1'b0;
        play_round(4, 1'b1);

        // Two buttons at once is a mismatch.
        start_game(1'b0);
        watch_display(1);
        botoes = 4'b0101;
        tick();
        botoes = '0;
        chk_out("multi_btn", 0, 4'b1010);

        // Reset in the middle of the round-3 display.
        start_game(1'b1);
        play_round(1, 1'b0);
        play_round(2, 1'b0);
        tick();
        chk("r3.leds_onehot", $countones(leds), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid.leds", int'(leds), 0);
        chk_out("rst_mid", 0, 4'b0000);
        tick();
        chk("rst_idle.leds", int'(leds), 0);
        chk_out("rst_idle", 0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
